// File: rtl/core_pkg.sv
// Shared core types: memory access direction, size and reservation kind.
package core_pkg;
  typedef enum logic {MEM_READ, MEM_WRITE} mem_dir_e;
  typedef enum logic [2:0] {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU} mem_size_e;
  typedef enum logic [1:0] {RSV_NONE, RSV_SET, RSV_CHECK} mem_rsv_e;
endpackage

// File: rtl/core_stage_mem_if.sv
// Core data bus between the memory stage (master) and the memory system (slave).
// Handshake: a request transfers on a cycle where dbus_req_valid && dbus_req_ready; the master holds
// every request field stable until then. dbus_rsp_valid is a single-cycle strobe, at least one cycle
// after acceptance, carrying dbus_rdata and dbus_rsp_err.
interface core_stage_mem_if;
  logic        dbus_req_valid;
  logic        dbus_req_ready;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_rsp_valid;
  logic [31:0] dbus_rdata;
  logic        dbus_rsp_err;

  modport master (
    output dbus_req_valid, dbus_addr, dbus_we, dbus_wstrb, dbus_wdata,
    input  dbus_req_ready, dbus_rsp_valid, dbus_rdata, dbus_rsp_err
  );
  modport slave (
    input  dbus_req_valid, dbus_addr, dbus_we, dbus_wstrb, dbus_wdata,
    output dbus_req_ready, dbus_rsp_valid, dbus_rdata, dbus_rsp_err
  );
endinterface

// File: rtl/core_stage_mem.sv
// Memory-access stage: issues one load/store/LR/SC/AMO access per controller handshake with
// byte-lane steering, extends read data, owns the LR/SC reservation and reports access faults.
module core_stage_mem
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_stage_valid,
  output logic              mem_stage_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  mem_dir_e          mem_dir,
  input  mem_size_e         mem_size,
  input  mem_rsv_e          mem_rsv,
  input  logic              rsv_clear,
  output logic              mem_rsv_valid,
  output logic [31:0]       mem_rdata,
  output logic [31:0]       mem_last_rdata,
  core_stage_mem_if.master  dbus,
  output logic              ex_load_access_fault,
  output logic              ex_store_access_fault,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state;
  logic        skip_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  mem_dir_e    dir_q;
  mem_size_e   size_q;
  mem_rsv_e    rsv_q;
  logic        rsv_v;
  logic [29:0] rsv_addr;

  logic        rsp_fire;
  logic        rd_ok;
  logic [1:0]  off;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic [3:0]  strb;
  logic [31:0] lane_wdata;

  assign off       = addr_q[1:0];
  assign rsp_fire  = (state == S_WAIT) && dbus.dbus_rsp_valid;
  assign rd_ok     = rsp_fire && !dbus.dbus_rsp_err && (dir_q == MEM_READ);
  assign state_dbg = state;

  assign mem_rsv_valid   = rsv_v && (rsv_addr == mem_addr[31:2]);
  // A skipped SC completes from IDLE via skip_q, so ready covers both paths.
  assign mem_stage_ready = rsp_fire || skip_q;

  always_comb begin
    strb       = 4'b1111;
    lane_wdata = wdata_q;
    case (size_q)
      MEM_B, MEM_BU: begin
        strb       = 4'b0001 << off;
        lane_wdata = {4{wdata_q[7:0]}};
      end
      MEM_H, MEM_HU: begin
        strb       = 4'b0011 << off;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        strb       = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    rd_shift = dbus.dbus_rdata >> {off, 3'b000};
    rd_ext   = rd_shift;
    case (size_q)
      MEM_B:   rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      MEM_H:   rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      MEM_BU:  rd_ext = {24'd0, rd_shift[7:0]};
      MEM_HU:  rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign mem_rdata = rd_ok ? rd_ext : 32'd0;

  assign dbus.dbus_req_valid = (state == S_REQ);
  assign dbus.dbus_addr      = {addr_q[31:2], 2'b00};
  assign dbus.dbus_we        = (state == S_REQ) && (dir_q == MEM_WRITE);
  assign dbus.dbus_wstrb     = (state == S_REQ) ? strb : 4'b0000;
  assign dbus.dbus_wdata     = lane_wdata;

  assign ex_load_access_fault  = rsp_fire && dbus.dbus_rsp_err && (dir_q == MEM_READ);
  assign ex_store_access_fault = rsp_fire && dbus.dbus_rsp_err && (dir_q == MEM_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      skip_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      dir_q   <= MEM_READ;
      size_q  <= MEM_W;
      rsv_q   <= RSV_NONE;
    end else begin
      skip_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // skip_q blocks re-acceptance while the controller still holds valid in the ready cycle.
          if (mem_stage_valid && !skip_q) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            dir_q   <= mem_dir;
            size_q  <= mem_size;
            rsv_q   <= mem_rsv;
            if ((mem_rsv == RSV_CHECK) && !mem_rsv_valid) skip_q <= 1'b1;
            else                                          state  <= S_REQ;
          end
        end
        S_REQ:   if (dbus.dbus_req_ready) state <= S_WAIT;
        S_WAIT:  if (dbus.dbus_rsp_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_v    <= 1'b0;
      rsv_addr <= 30'd0;
    end else if (rsv_clear) begin
      rsv_v <= 1'b0;
    end else if (skip_q) begin
      rsv_v <= 1'b0;
    end else if (rsp_fire && !dbus.dbus_rsp_err) begin
      if (rsv_q == RSV_SET) begin
        rsv_v    <= 1'b1;
        rsv_addr <= addr_q[31:2];
      end else if (rsv_q == RSV_CHECK) begin
        rsv_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mem_last_rdata <= 32'd0;
    else if (rd_ok) mem_last_rdata <= rd_ext;
  end

endmodule
